// File: rtl/map_pkg.sv
// Shared map ROM geometry, read-owner encoding and the per-read tag carried alongside a ROM access.
// No logic of its own; imported by the arbiter and the tag pipe.
package map_pkg;

   localparam int MAP_W            = 30;
   localparam int MAP_H            = 21;
   localparam int MAP_ADDR_W       = 5;
   localparam int MAP_STARVE_LIMIT = 1023;

   localparam logic OWNER_DISP = 1'b0;
   localparam logic OWNER_GAME = 1'b1;

   // Off-map rows read back as solid wall.
   localparam logic [MAP_W-1:0] OOR_ROW = '1;

   typedef struct packed {
      logic vld;
      logic owner;
      logic oor;
   } rd_tag_t;

endpackage

// File: rtl/rom_read_tag_pipe.sv
// Two-stage shift register carrying {valid, owner, oor} beside a synchronous-read ROM access.
// Latency: stage 1 lines up with ROM data, stage 2 with the registered read result.
// No backpressure: shifts every cycle, cleared by synchronous reset.
module rom_read_tag_pipe
   import map_pkg::*;
(
   input  logic    clk,
   input  logic    reset,
   input  rd_tag_t tag_in,
   output rd_tag_t tag_s1,
   output rd_tag_t tag_s2
);

   always_ff @(posedge clk) begin
      if (reset) begin
         tag_s1 <= '0;
         tag_s2 <= '0;
      end else begin
         tag_s1 <= tag_in;
         tag_s2 <= tag_s1;
      end
   end

endmodule

// File: rtl/map_rom_arbiter.sv
// Shares one synchronous-read map ROM between the display renderer (fixed priority) and the game logic.
// Latency: 2 cycles from grant to rvalid, fully pipelined.
// Backpressure: display is never stalled; game holds its request until granted, starvation is flagged.
module map_rom_arbiter
   import map_pkg::*;
#(
   parameter int DATA_W       = MAP_W,
   parameter int ADDR_W       = MAP_ADDR_W,
   parameter int DEPTH        = MAP_H,
   parameter int STARVE_LIMIT = MAP_STARVE_LIMIT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic              disp_gnt,
   output logic              disp_rvalid,
   output logic [DATA_W-1:0] disp_rdata,
   input  logic              game_req,
   input  logic [ADDR_W-1:0] game_addr,
   output logic              game_gnt,
   output logic              game_rvalid,
   output logic [DATA_W-1:0] game_rdata,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic              starve_err
);

   localparam int          CNT_W   = $clog2(STARVE_LIMIT + 1);
   localparam int unsigned DEPTH_U = DEPTH;

   logic              any_gnt;
   logic [ADDR_W-1:0] win_addr;
   logic [ADDR_W-1:0] held_addr;
   rd_tag_t           tag_in;
   rd_tag_t           tag_s1;
   rd_tag_t           tag_s2;
   logic              unused_s2_oor;
   logic              starve_wait;
   logic [CNT_W-1:0]  starve_cnt;
   logic [CNT_W-1:0]  starve_cnt_nxt;

   assign disp_gnt = disp_req;
   assign game_gnt = game_req & ~disp_req;
   assign any_gnt  = disp_req | game_req;
   assign win_addr = disp_req ? disp_addr : game_addr;

   // Idle cycles keep the last granted address so the ROM address bus does not toggle.
   assign rom_addr = any_gnt ? win_addr : held_addr;

   always_comb begin
      tag_in       = '0;
      tag_in.vld   = any_gnt;
      tag_in.owner = disp_req ? OWNER_DISP : OWNER_GAME;
      tag_in.oor   = any_gnt && (32'(win_addr) >= DEPTH_U);
   end

   rom_read_tag_pipe u_tag_pipe (
      .clk    (clk),
      .reset  (reset),
      .tag_in (tag_in),
      .tag_s1 (tag_s1),
      .tag_s2 (tag_s2)
   );

   // The range flag is consumed when data is captured; stage 2 only needs valid/owner.
   assign unused_s2_oor = tag_s2.oor;

   assign disp_rvalid = tag_s2.vld & (tag_s2.owner == OWNER_DISP);
   assign game_rvalid = tag_s2.vld & (tag_s2.owner == OWNER_GAME);

   always_ff @(posedge clk) begin
      if (reset) begin
         held_addr  <= '0;
         disp_rdata <= '0;
         game_rdata <= '0;
      end else begin
         if (any_gnt) begin
            held_addr <= win_addr;
         end
         if (tag_s1.vld) begin
            if (tag_s1.owner == OWNER_DISP) begin
               disp_rdata <= tag_s1.oor ? {DATA_W{1'b1}} : rom_data;
            end else begin
               game_rdata <= tag_s1.oor ? {DATA_W{1'b1}} : rom_data;
            end
         end
      end
   end

   assign starve_wait = game_req & ~game_gnt;

   always_comb begin
      starve_cnt_nxt = '0;
      if (starve_wait) begin
         starve_cnt_nxt = (starve_cnt == CNT_W'(STARVE_LIMIT)) ? starve_cnt
                                                               : starve_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt <= '0;
         starve_err <= 1'b0;
      end else begin
         starve_cnt <= starve_cnt_nxt;
         if (starve_cnt_nxt == CNT_W'(STARVE_LIMIT)) begin
            starve_err <= 1'b1;
         end
      end
   end

   a_one_grant : assert property (@(posedge clk) disable iff (reset) !(disp_gnt && game_gnt));

endmodule

// File: tb/tb_map_rom_arbiter.sv
// Bench for map_rom_arbiter: directed scenarios plus a randomized run against a scoreboard model.
module tb_map_rom_arbiter;
   import map_pkg::*;

   localparam int LIM = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        disp_req, game_req;
   logic [4:0]  disp_addr, game_addr;
   logic        disp_gnt, game_gnt, disp_rvalid, game_rvalid, starve_err;
   logic [29:0] disp_rdata, game_rdata, rom_data;
   logic [4:0]  rom_addr;

   always #5 clk = ~clk;

   map_rom_arbiter #(.STARVE_LIMIT(LIM)) dut (
      .clk(clk), .reset(reset),
      .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
      .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
      .game_req(game_req), .game_addr(game_addr), .game_gnt(game_gnt),
      .game_rvalid(game_rvalid), .game_rdata(game_rdata),
      .rom_addr(rom_addr), .rom_data(rom_data), .starve_err(starve_err)
   );

   logic [29:0] rom_mem [32];
   always @(posedge clk) rom_data <= rom_mem[rom_addr];

   typedef struct {
      int          due;
      bit          owner;
      logic [29:0] data;
   } rd_t;

   rd_t         pend[$];
   int          cyc = 0;
   int          compared = 0;
   int          mismatched = 0;
   int          wait_cnt = 0;
   logic        exp_dgnt, exp_ggnt, exp_dv, exp_gv, exp_err;
   logic [29:0] exp_dd, exp_gd;
   logic [4:0]  exp_addr, last_addr;

   function automatic logic [29:0] row_of(input logic [4:0] a);
      return (int'(a) >= MAP_H) ? 30'h3FFFFFFF : rom_mem[a];
   endfunction

   // Expected observable values for the current cycle (sampled at the falling edge).
   task automatic eval();
      @(negedge clk);
      exp_dgnt = disp_req;
      exp_ggnt = game_req & ~disp_req;
      exp_addr = disp_req ? disp_addr : (game_req ? game_addr : last_addr);
      exp_dv   = 1'b0;
      exp_gv   = 1'b0;
      while (pend.size() > 0 && pend[0].due == cyc) begin
         if (pend[0].owner == OWNER_DISP) begin
            exp_dv = 1'b1;
            exp_dd = pend[0].data;
         end else begin
            exp_gv = 1'b1;
            exp_gd = pend[0].data;
         end
         void'(pend.pop_front());
      end
   endtask

   // Advance the model across a rising edge, then let the caller change inputs.
   task automatic tick();
      @(posedge clk);
      if (reset) begin
         pend.delete();
         exp_dd = '0; exp_gd = '0; exp_err = 1'b0; wait_cnt = 0; last_addr = '0;
      end else begin
         if (disp_req) begin
            pend.push_back('{cyc + 2, OWNER_DISP, row_of(disp_addr)});
            last_addr = disp_addr;
         end else if (game_req) begin
            pend.push_back('{cyc + 2, OWNER_GAME, row_of(game_addr)});
            last_addr = game_addr;
         end
         if (game_req && disp_req) begin
            wait_cnt = (wait_cnt < LIM) ? wait_cnt + 1 : LIM;
            if (wait_cnt == LIM) exp_err = 1'b1;
         end else begin
            wait_cnt = 0;
         end
      end
      cyc++;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; disp_req = 0; game_req = 0; disp_addr = 5'd7; game_addr = 5'd9;
      repeat (3) tick();
      reset = 1'b0;
      eval();
      compared += 8;
      if (disp_rvalid !== 1'b0) begin mismatched++; $display("FAIL reset_disp_rvalid got %b want 0", disp_rvalid); end
      if (game_rvalid !== 1'b0) begin mismatched++; $display("FAIL reset_game_rvalid got %b want 0", game_rvalid); end
      if (disp_rdata !== 30'd0) begin mismatched++; $display("FAIL reset_disp_rdata got %h want 0", disp_rdata); end
      if (game_rdata !== 30'd0) begin mismatched++; $display("FAIL reset_game_rdata got %h want 0", game_rdata); end
      if (starve_err !== 1'b0) begin mismatched++; $display("FAIL reset_starve_err got %b want 0", starve_err); end
      if (disp_gnt !== 1'b0) begin mismatched++; $display("FAIL reset_disp_gnt got %b want 0", disp_gnt); end
      if (game_gnt !== 1'b0) begin mismatched++; $display("FAIL reset_game_gnt got %b want 0", game_gnt); end
      if (rom_addr !== 5'd0) begin mismatched++; $display("FAIL reset_rom_addr got %0d want 0", rom_addr); end
      tick();
   endtask

   task automatic test_single_display();
      disp_req = 1'b1; disp_addr = 5'd10;
      for (int k = 0; k < 4; k++) begin
         eval();
         compared += 3;
         if (disp_gnt !== (k == 0)) begin mismatched++; $display("FAIL single_gnt c%0d got %b want %b", k, disp_gnt, k == 0); end
         if (disp_rvalid !== (k == 2)) begin mismatched++; $display("FAIL single_rvalid c%0d got %b want %b", k, disp_rvalid, k == 2); end
         if (game_rvalid !== 1'b0) begin mismatched++; $display("FAIL single_game_rvalid c%0d got %b want 0", k, game_rvalid); end
         if (k >= 2) begin
            compared++;
            if (disp_rdata !== rom_mem[10]) begin mismatched++; $display("FAIL single_rdata c%0d got %h want %h", k, disp_rdata, rom_mem[10]); end
         end
         tick();
         disp_req = 1'b0; disp_addr = 5'd4;
      end
   endtask

   task automatic test_collision();
      disp_req = 1'b1; disp_addr = 5'd3; game_req = 1'b1; game_addr = 5'd11;
      for (int k = 0; k < 5; k++) begin
         eval();
         compared += 4;
         if (disp_gnt !== (k == 0)) begin mismatched++; $display("FAIL coll_disp_gnt c%0d got %b want %b", k, disp_gnt, k == 0); end
         if (game_gnt !== (k == 1)) begin mismatched++; $display("FAIL coll_game_gnt c%0d got %b want %b", k, game_gnt, k == 1); end
         if (disp_rvalid !== (k == 2)) begin mismatched++; $display("FAIL coll_disp_rvalid c%0d got %b want %b", k, disp_rvalid, k == 2); end
         if (game_rvalid !== (k == 3)) begin mismatched++; $display("FAIL coll_game_rvalid c%0d got %b want %b", k, game_rvalid, k == 3); end
         if (k >= 2) begin
            compared++;
            if (disp_rdata !== rom_mem[3]) begin mismatched++; $display("FAIL coll_disp_rdata c%0d got %h want %h", k, disp_rdata, rom_mem[3]); end
         end
         if (k >= 3) begin
            compared++;
            if (game_rdata !== rom_mem[11]) begin mismatched++; $display("FAIL coll_game_rdata c%0d got %h want %h", k, game_rdata, rom_mem[11]); end
         end
         tick();
         disp_req = 1'b0;
         if (k >= 1) game_req = 1'b0;
      end
   endtask

   task automatic test_out_of_range();
      game_req = 1'b1; game_addr = 5'd21;
      for (int k = 0; k < 5; k++) begin
         eval();
         compared += 3;
         if (game_gnt !== (k < 2)) begin mismatched++; $display("FAIL oor_gnt c%0d got %b want %b", k, game_gnt, k < 2); end
         if (game_rvalid !== (k == 2 || k == 3)) begin mismatched++; $display("FAIL oor_rvalid c%0d got %b want %b", k, game_rvalid, k == 2 || k == 3); end
         if (rom_addr !== ((k == 0) ? 5'd21 : 5'd31)) begin mismatched++; $display("FAIL oor_rom_addr c%0d got %0d want %0d", k, rom_addr, (k == 0) ? 21 : 31); end
         if (k >= 2) begin
            compared++;
            if (game_rdata !== 30'h3FFFFFFF) begin mismatched++; $display("FAIL oor_rdata c%0d got %h want 3fffffff", k, game_rdata); end
         end
         tick();
         game_addr = 5'd31;
         if (k >= 1) game_req = 1'b0;
      end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 24; k++) begin
         disp_req  = (k < 21);
         disp_addr = (k < 21) ? 5'(k) : 5'd0;
         eval();
         compared += 3;
         if (disp_gnt !== (k < 21)) begin mismatched++; $display("FAIL b2b_gnt c%0d got %b want %b", k, disp_gnt, k < 21); end
         if (disp_rvalid !== (k >= 2 && k < 23)) begin mismatched++; $display("FAIL b2b_rvalid c%0d got %b want %b", k, disp_rvalid, k >= 2 && k < 23); end
         if (rom_addr !== ((k < 21) ? 5'(k) : 5'd20)) begin mismatched++; $display("FAIL b2b_rom_addr c%0d got %0d", k, rom_addr); end
         if (k >= 2 && k < 23) begin
            compared++;
            if (disp_rdata !== rom_mem[k - 2]) begin mismatched++; $display("FAIL b2b_rdata c%0d got %h want %h", k, disp_rdata, rom_mem[k - 2]); end
         end
         tick();
      end
      disp_req = 1'b0;
   endtask

   task automatic test_random();
      logic acc;
      acc = 1'b1;
      for (int k = 0; k < 400; k++) begin
         reset     = ($urandom_range(0, 59) == 0);
         disp_req  = ($urandom_range(0, 2) == 0);
         disp_addr = 5'($urandom_range(0, 31));
         if (!game_req || acc) begin
            game_req  = $urandom_range(0, 1) == 1;
            game_addr = 5'($urandom_range(0, 31));
         end
         eval();
         compared += 8;
         if (disp_gnt !== exp_dgnt) begin mismatched++; $display("FAIL rnd_disp_gnt c%0d got %b want %b", k, disp_gnt, exp_dgnt); end
         if (game_gnt !== exp_ggnt) begin mismatched++; $display("FAIL rnd_game_gnt c%0d got %b want %b", k, game_gnt, exp_ggnt); end
         if (disp_rvalid !== exp_dv) begin mismatched++; $display("FAIL rnd_disp_rvalid c%0d got %b want %b", k, disp_rvalid, exp_dv); end
         if (game_rvalid !== exp_gv) begin mismatched++; $display("FAIL rnd_game_rvalid c%0d got %b want %b", k, game_rvalid, exp_gv); end
         if (disp_rdata !== exp_dd) begin mismatched++; $display("FAIL rnd_disp_rdata c%0d got %h want %h", k, disp_rdata, exp_dd); end
         if (game_rdata !== exp_gd) begin mismatched++; $display("FAIL rnd_game_rdata c%0d got %h want %h", k, game_rdata, exp_gd); end
         if (rom_addr !== exp_addr) begin mismatched++; $display("FAIL rnd_rom_addr c%0d got %0d want %0d", k, rom_addr, exp_addr); end
         if (starve_err !== exp_err) begin mismatched++; $display("FAIL rnd_starve_err c%0d got %b want %b", k, starve_err, exp_err); end
         acc = exp_ggnt;
         tick();
      end
      reset = 1'b0; disp_req = 1'b0; game_req = 1'b0;
   endtask

   task automatic test_starvation();
      reset = 1'b1;
      tick();
      reset = 1'b0; disp_req = 1'b1; disp_addr = 5'd2; game_req = 1'b1; game_addr = 5'd7;
      for (int k = 0; k < 12; k++) begin
         eval();
         compared++;
         if (starve_err !== (k >= LIM)) begin mismatched++; $display("FAIL starve_err after %0d waits got %b want %b", k, starve_err, k >= LIM); end
         tick();
      end
      disp_req = 1'b0;
      eval();
      compared += 2;
      if (game_gnt !== 1'b1) begin mismatched++; $display("FAIL starve_late_gnt got %b want 1", game_gnt); end
      if (starve_err !== 1'b1) begin mismatched++; $display("FAIL starve_sticky_gnt got %b want 1", starve_err); end
      tick();
      game_req = 1'b0;
      for (int k = 0; k < 3; k++) begin
         eval();
         compared++;
         if (starve_err !== 1'b1) begin mismatched++; $display("FAIL starve_sticky_idle c%0d got %b want 1", k, starve_err); end
         tick();
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      eval();
      compared++;
      if (starve_err !== 1'b0) begin mismatched++; $display("FAIL starve_reset_clear got %b want 0", starve_err); end
      tick();
   endtask

   task automatic test_reset_midflight();
      game_req = 1'b1; game_addr = 5'd5;
      eval();
      tick();
      game_req = 1'b0;
      eval();
      tick();
      eval();
      compared += 2;
      if (game_rvalid !== 1'b1) begin mismatched++; $display("FAIL mid_pre_rvalid got %b want 1", game_rvalid); end
      if (game_rdata !== rom_mem[5]) begin mismatched++; $display("FAIL mid_pre_rdata got %h want %h", game_rdata, rom_mem[5]); end
      tick();
      game_req = 1'b1; game_addr = 5'd12;
      eval();
      compared++;
      if (game_gnt !== 1'b1) begin mismatched++; $display("FAIL mid_gnt got %b want 1", game_gnt); end
      tick();
      game_req = 1'b0; reset = 1'b1;
      eval();
      tick();
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         eval();
         compared += 3;
         if (game_rvalid !== 1'b0) begin mismatched++; $display("FAIL mid_rvalid c%0d got %b want 0", k, game_rvalid); end
         if (game_rdata !== 30'd0) begin mismatched++; $display("FAIL mid_rdata c%0d got %h want 0", k, game_rdata); end
         if (starve_err !== 1'b0) begin mismatched++; $display("FAIL mid_starve_err c%0d got %b want 0", k, starve_err); end
         tick();
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rom_mem[i] = 30'($urandom);
      reset = 1'b1; disp_req = 1'b0; game_req = 1'b0; disp_addr = '0; game_addr = '0;
      exp_dd = '0; exp_gd = '0; exp_err = 1'b0; last_addr = '0;
      test_reset();
      test_single_display();
      test_collision();
      test_out_of_range();
      test_back_to_back();
      test_random();
      test_starvation();
      test_reset_midflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/map_rom_arbiter.md
Name: map_rom_arbiter

Overview:
Shares one synchronous-read map ROM (30-bit rows, 21 rows) between two requesters: the VGA pixel renderer (display port) and the game-logic collision checker (game port). The display port has fixed priority and is never stalled. The game port is served in any cycle the display is idle. Sits between the renderer/game FSM and the single map ROM instance, replacing the duplicated ROM.

Parameters:
DATA_W, 30, ROM row width (map columns)
ADDR_W, 5, ROM address width
DEPTH, 21, number of valid ROM rows (map rows)
STARVE_LIMIT, 1023, consecutive ungranted game-request cycles before starve_err sets

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
disp_req  in  1  display read request; pulsed only on row-address change
disp_addr  in  ADDR_W  display row address
disp_gnt  out  1  display request accepted this cycle
disp_rvalid  out  1  display read data valid (1-cycle pulse)
disp_rdata  out  DATA_W  display row data
game_req  in  1  game read request; held until game_gnt
game_addr  in  ADDR_W  game row address; stable while game_req high
game_gnt  out  1  game request accepted this cycle
game_rvalid  out  1  game read data valid (1-cycle pulse)
game_rdata  out  DATA_W  game row data
rom_addr  out  ADDR_W  address to ROM
rom_data  in  DATA_W  ROM output, valid 1 cycle after rom_addr sampled
starve_err  out  1  sticky flag: game port starved STARVE_LIMIT cycles

Behaviour:
- Reset: disp_rvalid=0, game_rvalid=0, disp_rdata=0, game_rdata=0, starve_err=0, starve counter=0, held address=0, tag pipeline cleared. The grant outputs are combinational, so they are 0 whenever their req is 0.
- Arbitration is combinational, in the same cycle as the request:
  - disp_gnt = disp_req.
  - game_gnt = game_req & ~disp_req.
  - At most one grant per cycle. A request is accepted when req and gnt are both high at a clk edge.
- rom_addr:
  - Equals the winner's address in a grant cycle.
  - Otherwise holds the last granted address, kept in a register, to avoid needless ROM toggling.
- Read latency is exactly 2 cycles.
  - Cycle N: grant.
  - End of N: ROM samples address.
  - Cycle N+1: rom_data valid; arbiter registers it.
  - Cycle N+2: the owner's rvalid=1 and rdata holds the row.
- Tag pipeline: 2 stages of {valid, owner, oor}.
  - owner: 0 = display, 1 = game.
  - oor (out of range) = granted addr >= DEPTH.
- rdata update rules:
  - rdata updates only on that port's rvalid cycle; otherwise it holds its value.
  - The non-owner port's rvalid stays 0.
- Out-of-range address: still granted, with normal latency. Returned rdata is forced to all-ones, so an off-map cell reads as a wall.
- Back-to-back: a new grant is allowed every cycle; there are no bubbles and the pipeline is fully pipelined.
  - Example: display grants in N and N+1 give disp_rvalid in N+2 and N+3.
- Simultaneous requests: display wins. The game request stays pending; the game requester must keep req and addr stable.
- Starvation counter:
  - Increments each cycle game_req & ~game_gnt.
  - Clears on game_gnt or when game_req is low.
  - Saturates at STARVE_LIMIT.
  - Reaching STARVE_LIMIT sets starve_err. starve_err is sticky and cleared only by reset.
- Reset mid-operation: in-flight reads are discarded. No rvalid fires in the cycles after reset deasserts unless a new grant occurred.
- Address width: disp_addr and game_addr are compared to DEPTH as unsigned ADDR_W values. The ROM is never given an address >= 2^ADDR_W.

Decomposition:
- Shared package map_pkg:
  - MAP_W=30, MAP_H=21, MAP_ADDR_W=5.
  - Owner constants OWNER_DISP=1'b0, OWNER_GAME=1'b1.
  - OOR_ROW fill value, all-ones of MAP_W.
- One sub-module, rom_read_tag_pipe: the 2-stage {valid, owner, oor} shift register with synchronous reset. It is reused by any future shared-ROM port (e.g. sprite ROM).

Test Plan:
1. Single display read: disp_req=1, disp_addr=10 in cycle 0 -> disp_gnt=1 in cycle 0; disp_rvalid=1 in cycle 2 with disp_rdata=ROM[10]; game_rvalid stays 0.
2. Collision: disp_req and game_req both high, disp_addr=3, game_addr=11, in cycle 0 -> only disp_gnt in cycle 0; game_gnt in cycle 1 (disp_req dropped); disp_rvalid cycle 2 = ROM[3]; game_rvalid cycle 3 = ROM[11].
3. Out of range: game_addr=21, then game_addr=31 -> each granted, game_rdata=30'h3FFFFFFF at +2 cycles.
4. Back-to-back: display rows 0..20 on consecutive cycles -> 21 consecutive disp_rvalid pulses starting cycle 2, data matches ROM order, no bubbles.
5. Starvation: STARVE_LIMIT=8, disp_req held high, game_req=1 -> starve_err=0 through 7 waiting cycles, 1 after the 8th; remains 1 after disp_req drops and the game is granted; cleared only by reset.
6. Reset mid-flight: grant the game at cycle 0, assert reset in cycle 1 -> game_rvalid never asserts, rdata=0, starve_err=0 after reset.
